// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and constants for the common data bus (CDB) arbiter slice.
// Holds the ROB index and data word types, the source numbering (alu=0, ld=1,
// br=2), the queued entry format and a small helper that steps the source
// index cyclically.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int unsigned ROB_IDX_W    = 4;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned CDB_SRC_NUM  = 3;
  localparam int unsigned CDB_FIFO_BIT = 1;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [WORD_W-1:0]    word_t;

  localparam rob_idx_t ZERO_ROB_IDX = '0;

  // Source numbering doubles as the round-robin order.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LD  = 2'd1,
    SRC_BR  = 2'd2
  } src_e;

  typedef struct packed {
    rob_idx_t src;
    word_t    val;
  } cdb_entry_t;

  // Next source in the cyclic order alu -> ld -> br -> alu.
  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_ALU: return SRC_LD;
      SRC_LD:  return SRC_BR;
      default: return SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the three result request ports, their queue-full flags and the
// registered CDB broadcast.
//   master : producer side (drives requests, observes full flags and CDB)
//   slave  : arbiter side  (observes requests, drives full flags and CDB)
// Signals:
//   alu_valid/alu_src/alu_val, ld_valid/ld_src/ld_val, br_valid/br_src/br_val
//   alu_full, ld_full, br_full
//   cdb_valid, cdb_src, cdb_val, cdb_ovf
// -----------------------------------------------------------------------------
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic     alu_valid;
  rob_idx_t alu_src;
  word_t    alu_val;
  logic     ld_valid;
  rob_idx_t ld_src;
  word_t    ld_val;
  logic     br_valid;
  rob_idx_t br_src;
  word_t    br_val;

  logic     alu_full;
  logic     ld_full;
  logic     br_full;

  logic     cdb_valid;
  rob_idx_t cdb_src;
  word_t    cdb_val;
  logic     cdb_ovf;

  modport master (
    output alu_valid, alu_src, alu_val,
    output ld_valid,  ld_src,  ld_val,
    output br_valid,  br_src,  br_val,
    input  alu_full,  ld_full, br_full,
    input  cdb_valid, cdb_src, cdb_val, cdb_ovf
  );

  modport slave (
    input  alu_valid, alu_src, alu_val,
    input  ld_valid,  ld_src,  ld_val,
    input  br_valid,  br_src,  br_val,
    output alu_full,  ld_full, br_full,
    output cdb_valid, cdb_src, cdb_val, cdb_ovf
  );

endinterface

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// Per-source result queue of depth 2**FIFO_BIT.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous flush (takes priority over push/pop)
//   push/din : enqueue din; ignored while full
//   pop      : dequeue head; ignored while empty
//   full     : count == depth (count before the edge)
//   empty    : count == 0
//   head     : oldest entry
// -----------------------------------------------------------------------------
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_BIT = CDB_FIFO_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output logic       full,
  output logic       empty,
  output cdb_entry_t head
);

  localparam int unsigned DEPTH = 1 << FIFO_BIT;
  localparam logic [FIFO_BIT:0] DEPTH_CNT = {1'b1, {FIFO_BIT{1'b0}}};

  cdb_entry_t          mem [DEPTH];
  logic [FIFO_BIT-1:0] rd_ptr;
  logic [FIFO_BIT-1:0] wr_ptr;
  logic [FIFO_BIT:0]   cnt;
  logic                do_push;
  logic                do_pop;

  assign full    = (cnt == DEPTH_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign head    = mem[rd_ptr];

  // Pointers are exactly FIFO_BIT wide, so increments wrap modulo depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Merges ALU, load and branch results onto the single common data bus.
// Each source has its own queue; one head is popped per cycle and registered
// onto cdb_* (request sampled at edge N, broadcast after edge N+1).
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   rdy     : global ready; low freezes queues/pointer/overflow, cdb_valid=0
//   cdb_rb  : rollback flush; empties queues, cdb_valid=0, grant pointer=0
//   bus     : cdb_arbiter_if.slave (requests, full flags, CDB broadcast,
//             sticky overflow flag cdb_ovf)
// Configuration:
//   CDB_RR_ARB_EN defined   : round-robin grant starting after last winner
//   CDB_RR_ARB_EN undefined : fixed priority ld > alu > br
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_BIT = CDB_FIFO_BIT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           cdb_rb,
  cdb_arbiter_if.slave   bus
);

  logic [CDB_SRC_NUM-1:0] req_valid;
  logic [CDB_SRC_NUM-1:0] full;
  logic [CDB_SRC_NUM-1:0] empty;
  logic [CDB_SRC_NUM-1:0] push;
  logic [CDB_SRC_NUM-1:0] pop;
  logic [CDB_SRC_NUM-1:0] gnt_oh;
  cdb_entry_t             req  [CDB_SRC_NUM];
  cdb_entry_t             head [CDB_SRC_NUM];

  logic     gnt_any;
  src_e     gnt_src;
  logic     advance;

  logic     cdb_valid;
  rob_idx_t cdb_src;
  word_t    cdb_val;
  logic     cdb_ovf;

  // ---------------------------------------------------------------------------
  // Request collection
  // ---------------------------------------------------------------------------
  assign req_valid[SRC_ALU] = bus.alu_valid;
  assign req_valid[SRC_LD]  = bus.ld_valid;
  assign req_valid[SRC_BR]  = bus.br_valid;

  assign req[SRC_ALU] = '{src: bus.alu_src, val: bus.alu_val};
  assign req[SRC_LD]  = '{src: bus.ld_src,  val: bus.ld_val};
  assign req[SRC_BR]  = '{src: bus.br_src,  val: bus.br_val};

  // State moves only on a ready, non-rollback cycle.
  assign advance = rdy && !cdb_rb;

  // full is the pre-edge count, so a full queue drops its push even if it is
  // also being popped this cycle.
  assign push = req_valid & ~full & {CDB_SRC_NUM{advance}};
  assign pop  = gnt_oh & {CDB_SRC_NUM{advance}};

  // ---------------------------------------------------------------------------
  // Per-source queues
  // ---------------------------------------------------------------------------
  cdb_fifo #(.FIFO_BIT(FIFO_BIT)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (cdb_rb),
    .push  (push[SRC_ALU]),
    .pop   (pop[SRC_ALU]),
    .din   (req[SRC_ALU]),
    .full  (full[SRC_ALU]),
    .empty (empty[SRC_ALU]),
    .head  (head[SRC_ALU])
  );

  cdb_fifo #(.FIFO_BIT(FIFO_BIT)) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (cdb_rb),
    .push  (push[SRC_LD]),
    .pop   (pop[SRC_LD]),
    .din   (req[SRC_LD]),
    .full  (full[SRC_LD]),
    .empty (empty[SRC_LD]),
    .head  (head[SRC_LD])
  );

  cdb_fifo #(.FIFO_BIT(FIFO_BIT)) u_br_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (cdb_rb),
    .push  (push[SRC_BR]),
    .pop   (pop[SRC_BR]),
    .din   (req[SRC_BR]),
    .full  (full[SRC_BR]),
    .empty (empty[SRC_BR]),
    .head  (head[SRC_BR])
  );

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
`ifdef CDB_RR_ARB_EN
  // ptr names the highest-priority source for this cycle: one past the
  // last winner.
  src_e ptr;
  src_e cand1;
  src_e cand2;

  always_comb begin
    cand1   = next_src(ptr);
    cand2   = next_src(cand1);
    gnt_any = 1'b1;
    gnt_src = SRC_ALU;
    if (!empty[ptr])        gnt_src = ptr;
    else if (!empty[cand1]) gnt_src = cand1;
    else if (!empty[cand2]) gnt_src = cand2;
    else                    gnt_any = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SRC_ALU;
    end else if (cdb_rb) begin
      ptr <= SRC_ALU;
    end else if (rdy && gnt_any) begin
      ptr <= next_src(gnt_src);
    end
  end
`else
  always_comb begin
    gnt_any = 1'b1;
    gnt_src = SRC_ALU;
    if (!empty[SRC_LD])       gnt_src = SRC_LD;
    else if (!empty[SRC_ALU]) gnt_src = SRC_ALU;
    else if (!empty[SRC_BR])  gnt_src = SRC_BR;
    else                      gnt_any = 1'b0;
  end
`endif

  always_comb begin
    gnt_oh = '0;
    if (gnt_any) gnt_oh[gnt_src] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registered broadcast and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_src   <= ZERO_ROB_IDX;
      cdb_val   <= '0;
      cdb_ovf   <= FALSE;
    end else if (cdb_rb) begin
      cdb_valid <= 1'b0;
    end else if (rdy) begin
      cdb_valid <= gnt_any;
      if (gnt_any) begin
        cdb_src <= head[gnt_src].src;
        cdb_val <= head[gnt_src].val;
      end
      if (|(req_valid & full)) cdb_ovf <= TRUE;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  assign bus.alu_full  = full[SRC_ALU];
  assign bus.ld_full   = full[SRC_LD];
  assign bus.br_full   = full[SRC_BR];
  assign bus.cdb_valid = cdb_valid;
  assign bus.cdb_src   = cdb_src;
  assign bus.cdb_val   = cdb_val;
  assign bus.cdb_ovf   = cdb_ovf;

endmodule
